pwm_deadtime_gen: RTL and testbench
===================================

// Module: pwm_deadtime_gen
// PURPOSE
//  Downstream stage of the PWM generator. Turns its single pwm_out into a complementary
//  half-bridge pair (out_hi/out_lo) with programmable rising/falling dead time and a
//  latched fault shutdown. Memory-mapped slave on the same SoC peripheral bus.
// PARAMETERS
//  DT_W  16  dead-time counter width in clk ticks; legal range 1..16
// PORTS
//  clk      in   1   system clock
//  resetn   in   1   synchronous, active-low reset
//  i_sel    in   1   chip select
//  i_we     in   1   write enable
//  i_addr   in   4   register offset (mem_addr[3:0])
//  i_wdata  in   32  write data
//  o_rdata  out  32  read data, combinational
//  pwm_in   in   1   PWM from the generator, same clk domain, no synchroniser
//  fault_in in   1   active-high shutdown request, same clk domain
//  out_hi   out  1   high-side gate drive, registered
//  out_lo   out  1   low-side gate drive, registered
// BEHAVIOUR
//  Registers:
//   0x0 CTRL: [0] EN (R/W); [1] FAULT_CLR (write-1 pulse, reads 0).
//   0x4 DT: [DT_W-1:0] DT_RISE; [16+DT_W-1:16] DT_FALL. Other bits are ignored and read 0.
//   0x8 reserved. Reads 0, writes ignored.
//   0xC STATUS (RO): [2:0] state; [3] FAULT sticky; [31:16] dead-time count, zero-extended.
//  o_rdata is 0 when !(i_sel && !i_we).
//  Reset values: CTRL=0, DT=0, FAULT=0, state=OFF, out_hi=0, out_lo=0, cnt=0.
//  Reset asserted mid-operation forces these values at the next edge.
//  FSM (pkg encoding): OFF=0, DEAD_R=1, HI_ON=2, DEAD_F=3, LO_ON=4, FAULT=5.
//   Outputs by state: out_hi=1 only in HI_ON; out_lo=1 only in LO_ON; both 0 elsewhere.
//   Outputs are registered with the state, so they change on the same edge as the state.
//   OFF: when EN=1, go to DEAD_R if pwm_in=1 (cnt<=DT_RISE); otherwise DEAD_F (cnt<=DT_FALL).
//   LO_ON: if pwm_in=1, go to DEAD_R with cnt<=DT_RISE.
//   HI_ON: if pwm_in=0, go to DEAD_F with cnt<=DT_FALL.
//   DEAD_R: if pwm_in=0, abort to DEAD_F with cnt<=DT_FALL.
//     Otherwise, cnt==0 goes to HI_ON; else cnt-1.
//   DEAD_F: mirror of DEAD_R (abort to DEAD_R; cnt==0 goes to LO_ON).
//   Pulses shorter than the dead time are swallowed; both outputs stay 0.
//  Timing: pwm_in sampled high at edge k from LO_ON:
//   out_lo=0 after edge k; out_hi=1 after edge k+DT_RISE+1.
//   DT=0 still gives 1 cycle of non-overlap.
//   out_hi and out_lo are never 1 in the same cycle, under any register or input sequence.
//  Priority, highest first: resetn, fault, EN=0, FSM.
//   fault_in=1 in any state: state FAULT and FAULT<=1, so both outputs are 0 after that edge.
//   FAULT: leave to OFF only on a CTRL write with FAULT_CLR=1 while fault_in=0.
//     FAULT_CLR while fault_in=1 is ignored and FAULT stays set.
//   EN=0 in any non-FAULT state: OFF next edge, both outputs 0, cnt<=0.
//  Register writes:
//   A DT write takes effect at the next counter load; a running dead time keeps its count.
//   A CTRL write and a fault_in rise in the same cycle: the fault wins, and EN is still updated.
// STRUCTURE
//  Shared pwm_pkg: register offsets (CTRL/DT/STATUS), CTRL bit indices, FSM state
//   localparams, DT field positions. The pwm_ip offsets move into the same package.
//  Sub-module pwm_dt_counter (load/decrement/zero flag, width DT_W) holds the dead-time counter.
//  The FSM, the register file and the bus read mux stay in the top level.
// TESTING
//  1. DT_RISE=3, DT_FALL=5, EN=1, pwm_in 20 high / 20 low:
//     out_hi rises 4 cycles after the rise; out_lo rises 6 cycles after the fall; no overlap.
//  2. DT=0, pwm_in toggling every cycle: both outputs stay 0.
//     pwm_in held 3 cycles: the matching output is 1 for exactly 2 cycles.
//  3. DT_RISE=10, 4-cycle pwm_in high pulse from LO_ON: out_hi never asserts;
//     out_lo returns DT_FALL+1 cycles after the fall; STATUS.state shows 1 then 3.
//  4. fault_in pulsed 1 cycle during HI_ON: out_hi=0 next edge; STATUS=FAULT, bit3=1.
//     Toggling EN has no effect. FAULT_CLR with fault_in=1: still FAULT.
//     FAULT_CLR with fault_in=0: OFF, then normal restart.
//  5. EN cleared mid DEAD_R with cnt=7: OFF next edge, outputs 0, STATUS[31:16]=0.
//     resetn low mid HI_ON: all registers return to reset values.
//  6. Bus: write DT=0xFFFF_FFFF with DT_W=8 -> DT reads 0x00FF_00FF.
//     Reads of 0x8 and unselected reads return 0. CTRL bit1 reads 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared register map, field positions and FSM encoding for the PWM peripheral family.
package pwm_pkg;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_DT     = 4'h4;
    localparam logic [3:0] REG_RSVD   = 4'h8;
    localparam logic [3:0] REG_STATUS = 4'hC;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_FAULT_CLR = 1;

    localparam int DT_RISE_LSB    = 0;
    localparam int DT_FALL_LSB    = 16;

    localparam int STATUS_FAULT   = 3;
    localparam int STATUS_CNT_LSB = 16;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_DEAD_R = 3'd1,
        ST_HI_ON  = 3'd2,
        ST_DEAD_F = 3'd3,
        ST_LO_ON  = 3'd4,
        ST_FAULT  = 3'd5
    } dt_state_e;

endpackage

// File: rtl/pwm_dt_counter.sv
// Dead-time down-counter: clear, load, decrement, with a zero flag for the FSM.
module pwm_dt_counter #(
    parameter int DT_W = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            clear,
    input  logic            load,
    input  logic [DT_W-1:0] load_val,
    input  logic            dec,
    output logic [DT_W-1:0] cnt,
    output logic            zero
);

    localparam logic [DT_W-1:0] ONE = DT_W'(1);

    // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - ONE;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary half-bridge driver with programmable rise/fall dead time and latched fault.
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int DT_W = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_sel,
    input  logic        i_we,
    input  logic [3:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    input  logic        pwm_in,
    input  logic        fault_in,
    output logic        out_hi,
    output logic        out_lo
);

    dt_state_e       state, state_nxt;
    logic            en;
    logic            fault_flag;
    logic [DT_W-1:0] dt_rise, dt_fall;
    logic [DT_W-1:0] cnt, load_val;
    logic            cnt_zero, cnt_load, cnt_clear, cnt_dec;
    logic            ctrl_wr, dt_wr, fault_clr;
    logic            unused_wdata;

    assign ctrl_wr      = i_sel && i_we && (i_addr == REG_CTRL);
    assign dt_wr        = i_sel && i_we && (i_addr == REG_DT);
    assign fault_clr    = ctrl_wr && i_wdata[CTRL_FAULT_CLR];
    assign unused_wdata = ^i_wdata;

    pwm_dt_counter #(.DT_W(DT_W)) u_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_clear = 1'b0;
        cnt_dec   = 1'b0;
        load_val  = dt_rise;
        if (fault_in) begin
            state_nxt = ST_FAULT;
        end else if (state == ST_FAULT) begin
            if (fault_clr) state_nxt = ST_OFF;
        end else if (!en) begin
            state_nxt = ST_OFF;
            cnt_clear = 1'b1;
        end else begin
            unique case (state)
                ST_OFF, ST_LO_ON, ST_HI_ON: begin
                    if (pwm_in && state != ST_HI_ON) begin
                        state_nxt = ST_DEAD_R;
                        cnt_load  = 1'b1;
                    end else if (!pwm_in && state != ST_LO_ON) begin
                        state_nxt = ST_DEAD_F;
                        cnt_load  = 1'b1;
                        load_val  = dt_fall;
                    end
                end
                ST_DEAD_R: begin
                    if (!pwm_in) begin
                        state_nxt = ST_DEAD_F;
                        cnt_load  = 1'b1;
                        load_val  = dt_fall;
                    end else if (cnt_zero) begin
                        state_nxt = ST_HI_ON;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_DEAD_F: begin
                    if (pwm_in) begin
                        state_nxt = ST_DEAD_R;
                        cnt_load  = 1'b1;
                    end else if (cnt_zero) begin
                        state_nxt = ST_LO_ON;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_OFF;
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    // Gate drives decode the next state so they switch on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_OFF;
            out_hi     <= 1'b0;
            out_lo     <= 1'b0;
            en         <= 1'b0;
            fault_flag <= 1'b0;
            dt_rise    <= '0;
            dt_fall    <= '0;
        end else begin
            state  <= state_nxt;
            out_hi <= (state_nxt == ST_HI_ON);
            out_lo <= (state_nxt == ST_LO_ON);
            if (ctrl_wr) en <= i_wdata[CTRL_EN];
            if (dt_wr) begin
                dt_rise <= i_wdata[DT_RISE_LSB +: DT_W];
                dt_fall <= i_wdata[DT_FALL_LSB +: DT_W];
            end
            if (fault_in) begin
                fault_flag <= 1'b1;
            end else if (state == ST_FAULT && fault_clr) begin
                fault_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        if (i_sel && !i_we) begin
            case (i_addr)
                REG_CTRL: o_rdata[CTRL_EN] = en;
                REG_DT: begin
                    o_rdata[DT_RISE_LSB +: DT_W] = dt_rise;
                    o_rdata[DT_FALL_LSB +: DT_W] = dt_fall;
                end
                REG_STATUS: begin
                    o_rdata[2:0]                    = state;
                    o_rdata[STATUS_FAULT]           = fault_flag;
                    o_rdata[STATUS_CNT_LSB +: DT_W] = cnt;
                end
                default: o_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen: gate-drive expectations are queued per cycle, registers checked inline.
module tb_pwm_deadtime_gen;
    import pwm_pkg::*;

    localparam int DT_W = 8;

    logic        clk, resetn, i_sel, i_we, pwm_in, fault_in, out_hi, out_lo;
    logic [3:0]  i_addr;
    logic [31:0] i_wdata, o_rdata;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        int   at;
        int   id;
        logic hi;
        logic lo;
    } exp_t;
    exp_t sbq[$];

    pwm_deadtime_gen #(.DT_W(DT_W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .i_sel    (i_sel),
        .i_we     (i_we),
        .i_addr   (i_addr),
        .i_wdata  (i_wdata),
        .o_rdata  (o_rdata),
        .pwm_in   (pwm_in),
        .fault_in (fault_in),
        .out_hi   (out_hi),
        .out_lo   (out_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    // Output monitor: pops every expectation due in this cycle and checks for shoot-through.
    always @(negedge clk) begin
        exp_t e;
        n_checks++;
        assert ((out_hi & out_lo) !== 1'b1)
        else begin
            n_err++;
            $error("FAIL overlap cyc=%0d got hi=%b lo=%b want not both 1", cyc, out_hi, out_lo);
        end
        while (sbq.size() > 0 && sbq[0].at <= cyc) begin
            e = sbq.pop_front();
            n_checks++;
            assert (e.at == cyc && out_hi === e.hi && out_lo === e.lo)
            else begin
                n_err++;
                $error("FAIL outs_t%0d cyc=%0d due=%0d got hi=%b lo=%b want hi=%b lo=%b",
                       e.id, cyc, e.at, out_hi, out_lo, e.hi, e.lo);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    // Drive pwm_in for one cycle and queue the outputs expected right after the next edge.
    task automatic drive(int id, logic p, logic hi, logic lo);
        exp_t e;
        pwm_in = p;
        e.at = cyc + 1;
        e.id = id;
        e.hi = hi;
        e.lo = lo;
        sbq.push_back(e);
        tick();
    endtask

    task automatic bus_wr(logic [3:0] a, logic [31:0] d);
        i_sel   = 1'b1;
        i_we    = 1'b1;
        i_addr  = a;
        i_wdata = d;
        tick();
        i_sel   = 1'b0;
        i_we    = 1'b0;
        i_wdata = '0;
    endtask

    task automatic check_reg(string tag, logic [3:0] a, logic [31:0] exp, logic [31:0] mask);
        logic [31:0] d;
        i_sel  = 1'b1;
        i_we   = 1'b0;
        i_addr = a;
        #1;
        d     = o_rdata;
        i_sel = 1'b0;
        check(tag, d & mask, exp & mask);
    endtask

    initial begin
        resetn   = 1'b0;
        i_sel    = 1'b0;
        i_we     = 1'b0;
        i_addr   = '0;
        i_wdata  = '0;
        pwm_in   = 1'b0;
        fault_in = 1'b0;
        repeat (3) tick();

        check("rst_hi", 32'(out_hi), 32'd0);
        check("rst_lo", 32'(out_lo), 32'd0);
        check_reg("rst_ctrl", REG_CTRL, 32'd0, '1);
        check_reg("rst_dt", REG_DT, 32'd0, '1);
        check_reg("rst_status", REG_STATUS, 32'd0, '1);
        resetn = 1'b1;
        tick();

        // 1: DT_RISE=3, DT_FALL=5, 20 high / 20 low
        bus_wr(REG_DT, 32'h0005_0003);
        bus_wr(REG_CTRL, 32'd1);
        for (int i = 0; i < 10; i++) drive(1, 1'b0, 1'b0, i >= 6);
        for (int i = 0; i < 20; i++) drive(1, 1'b1, i >= 4, 1'b0);
        for (int i = 0; i < 20; i++) drive(1, 1'b0, 1'b0, i >= 6);

        // 2: zero dead time, toggling swallowed, 3-cycle pulse gives 2 cycles of out_hi
        bus_wr(REG_DT, 32'd0);
        for (int i = 0; i < 10; i++) drive(2, (i % 2) == 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(2, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) drive(2, i < 3, (i == 1) || (i == 2), i >= 4);

        // 3: pulse shorter than DT_RISE=10 is swallowed, fall dead time runs from the abort
        bus_wr(REG_DT, 32'h0005_000A);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) check_reg("t3_st_dead_r", REG_STATUS, 32'h000A_0001, '1);
            drive(3, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 1) check_reg("t3_st_dead_f", REG_STATUS, 32'h0005_0003, '1);
            drive(3, 1'b0, 1'b0, i >= 6);
        end

        // 4: fault during HI_ON, EN ignored, clear only while fault_in is low
        bus_wr(REG_DT, 32'h0002_0002);
        for (int i = 0; i < 6; i++) drive(4, 1'b1, i >= 3, 1'b0);
        fault_in = 1'b1;
        drive(4, 1'b1, 1'b0, 1'b0);
        fault_in = 1'b0;
        check_reg("t4_st_fault", REG_STATUS, 32'hD, 32'hF);
        bus_wr(REG_CTRL, 32'd0);
        check_reg("t4_en0_fault", REG_STATUS, 32'hD, 32'hF);
        bus_wr(REG_CTRL, 32'd1);
        check_reg("t4_en1_fault", REG_STATUS, 32'hD, 32'hF);
        check("t4_hi_off", 32'(out_hi), 32'd0);
        fault_in = 1'b1;
        bus_wr(REG_CTRL, 32'd2);
        fault_in = 1'b0;
        check_reg("t4_clr_blocked", REG_STATUS, 32'hD, 32'hF);
        check_reg("t4_en_upd", REG_CTRL, 32'd0, '1);
        bus_wr(REG_CTRL, 32'd3);
        check_reg("t4_cleared", REG_STATUS, 32'h0, 32'hF);
        check_reg("t4_ctrl_rd", REG_CTRL, 32'd1, '1);
        for (int i = 0; i < 6; i++) drive(4, 1'b1, i >= 3, 1'b0);

        // 5: EN cleared mid DEAD_R, then reset mid HI_ON
        bus_wr(REG_DT, 32'h0002_000A);
        for (int i = 0; i < 5; i++) drive(5, 1'b0, 1'b0, i >= 3);
        for (int i = 0; i < 4; i++) drive(5, 1'b1, 1'b0, 1'b0);
        check_reg("t5_cnt7", REG_STATUS, 32'h0007_0001, '1);
        bus_wr(REG_CTRL, 32'd0);
        tick();
        check_reg("t5_off", REG_STATUS, 32'd0, '1);
        check("t5_hi", 32'(out_hi), 32'd0);
        check("t5_lo", 32'(out_lo), 32'd0);
        bus_wr(REG_DT, 32'h0001_0001);
        bus_wr(REG_CTRL, 32'd1);
        for (int i = 0; i < 4; i++) drive(5, 1'b1, i >= 2, 1'b0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("t5_rst_hi", 32'(out_hi), 32'd0);
        check("t5_rst_lo", 32'(out_lo), 32'd0);
        check_reg("t5_rst_ctrl", REG_CTRL, 32'd0, '1);
        check_reg("t5_rst_dt", REG_DT, 32'd0, '1);
        check_reg("t5_rst_status", REG_STATUS, 32'd0, '1);

        // 6: bus field widths, reserved and unselected reads
        bus_wr(REG_DT, 32'hFFFF_FFFF);
        check_reg("t6_dt_mask", REG_DT, 32'h00FF_00FF, '1);
        bus_wr(REG_RSVD, 32'hFFFF_FFFF);
        check_reg("t6_rsvd", REG_RSVD, 32'd0, '1);
        i_sel  = 1'b0;
        i_addr = REG_DT;
        #1;
        check("t6_unsel", o_rdata, 32'd0);
        i_sel = 1'b1;
        i_we  = 1'b1;
        #1;
        check("t6_write_phase", o_rdata, 32'd0);
        i_sel = 1'b0;
        i_we  = 1'b0;
        bus_wr(REG_CTRL, 32'd3);
        check_reg("t6_ctrl_bit1", REG_CTRL, 32'd1, '1);

        for (int i = 0; i < 5 && sbq.size() > 0; i++) tick();
        check("sb_drain", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
